// File: rtl/enum_seq_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enum_seq_pkg
//  Description : Shared enum types and the symbol successor function for
//                the enumerated state-sequence tracker.
//  Revision    : 1.0  initial release
// ============================================================================
package enum_seq_pkg;

    // Symbols emitted by the enum-driven sequencers; ts3 is never legal
    typedef enum logic [1:0] {
        ts0 = 2'd0,
        ts1 = 2'd1,
        ts2 = 2'd2,
        ts3 = 2'd3
    } states_t;

    // Lock acquisition / tracking FSM
    typedef enum logic [1:0] {
        L_HUNT   = 2'd0,
        L_SYNC   = 2'd1,
        L_LOCKED = 2'd2,
        L_LOST   = 2'd3
    } lock_state_t;

    // Successor in the ts0 -> ts1 -> ts2 -> ts0 cycle; ts3 restarts at ts0
    function automatic states_t next_sym(input states_t s);
        case (s)
            ts0:     next_sym = ts1;
            ts1:     next_sym = ts2;
            default: next_sym = ts0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/enum_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : enum_sat_counter
//  Description : W-bit saturating up-counter with synchronous clear that
//                takes priority over the increment.
//  Revision    : 1.0  initial release
// ============================================================================
module enum_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (inc && (q_q != '1)) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/enum_seq_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : enum_seq_tracker
//  Description : Acquires lock on the ts0->ts1->ts2 symbol cycle, then
//                flywheels the prediction and flags / counts deviations.
//  Revision    : 1.0  initial release
// ============================================================================
module enum_seq_tracker
    import enum_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  states_t          in_sym,
    input  logic             err_clr,
    output logic             locked,
    output states_t          expected,
    output logic             err_pulse,
    output logic             illegal,
    output logic             lost,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam logic [GW-1:0] c_LOCK_TGT = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] c_LOSS_TGT = BW'(LOSS_COUNT);

    lock_state_t    state_q, state_d;
    states_t        expected_q, expected_d;
    logic [GW-1:0]  good_cnt_q, good_cnt_d;
    logic [BW-1:0]  bad_cnt_q, bad_cnt_d;
    logic           locked_q;
    logic           err_pulse_q, illegal_q, lost_q;
    logic           err_d, illegal_d, lost_d;

    // Next-state, prediction, counters and event strobes
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = 1'b0;
        illegal_d  = 1'b0;
        lost_d     = 1'b0;

        if (state_q == L_LOST) begin
            // Single-cycle state: input ignored apart from the ts3 flag
            illegal_d = in_valid && (in_sym == ts3);
            state_d   = L_HUNT;
        end else if (in_valid) begin
            case (state_q)
                L_HUNT: begin
                    if (in_sym == ts3) begin
                        illegal_d = 1'b1;
                    end else begin
                        expected_d = next_sym(in_sym);
                        good_cnt_d = '0;
                        state_d    = L_SYNC;
                    end
                end
                L_SYNC: begin
                    if (in_sym == ts3) begin
                        illegal_d = 1'b1;
                        state_d   = L_HUNT;
                    end else if (in_sym == expected_q) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        expected_d = next_sym(in_sym);
                        if (good_cnt_d == c_LOCK_TGT) begin
                            bad_cnt_d = '0;
                            state_d   = L_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                        expected_d = next_sym(in_sym);
                    end
                end
                L_LOCKED: begin
                    illegal_d  = (in_sym == ts3);
                    // Flywheel: prediction advances from itself, never from
                    // the received symbol
                    expected_d = next_sym(expected_q);
                    if (in_sym == expected_q) begin
                        bad_cnt_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        bad_cnt_d = bad_cnt_q + 1'b1;
                        if (bad_cnt_d == c_LOSS_TGT) begin
                            lost_d  = 1'b1;
                            state_d = L_LOST;
                        end
                    end
                end
                default: state_d = L_HUNT;
            endcase
        end
    end

    // State, prediction and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= L_HUNT;
            expected_q  <= ts0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            illegal_q   <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= (state_d == L_LOCKED);
            err_pulse_q <= err_d;
            illegal_q   <= illegal_d;
            lost_q      <= lost_d;
        end
    end

    enum_sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_d),
        .clr   (err_clr),
        .q     (err_count)
    );

    assign locked    = locked_q;
    assign expected  = expected_q;
    assign err_pulse = err_pulse_q;
    assign illegal   = illegal_q;
    assign lost      = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_enum_seq_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enum_seq_tracker
//  Description : Self-checking bench for enum_seq_tracker; a behavioural
//                model feeds an expected-result queue per driven cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_enum_seq_tracker;
    import enum_seq_pkg::*;

    localparam int LOCK_N = 3;
    localparam int LOSS_N = 2;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    in_valid = 1'b0;
    states_t in_sym = ts0;
    logic    err_clr = 1'b0;

    logic    locked_a, err_pulse_a, illegal_a, lost_a;
    states_t expected_a;
    logic [7:0] err_count_a;
    logic    locked_b, err_pulse_b, illegal_b, lost_b;
    states_t expected_b;
    logic [1:0] err_count_b;

    always #5 clk = ~clk;

    enum_seq_tracker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
        .err_clr(err_clr), .locked(locked_a), .expected(expected_a),
        .err_pulse(err_pulse_a), .illegal(illegal_a), .lost(lost_a),
        .err_count(err_count_a)
    );

    enum_seq_tracker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
        .err_clr(err_clr), .locked(locked_b), .expected(expected_b),
        .err_pulse(err_pulse_b), .illegal(illegal_b), .lost(lost_b),
        .err_count(err_count_b)
    );

    typedef struct {
        int lk; int ex; int ep; int il; int ls; int ec; int es;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // model state: 0 hunt, 1 sync, 2 locked, 3 lost
    int m_st, m_exp, m_good, m_bad, m_errc, m_errs;

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic int nx(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_exp = 0; m_good = 0; m_bad = 0; m_errc = 0; m_errs = 0;
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge
    task automatic step(input int v, input int s, input int c);
        exp_t e;
        int ep, il, ls;
        ep = 0; il = 0; ls = 0;
        in_valid = v[0];
        in_sym   = states_t'(s[1:0]);
        err_clr  = c[0];
        if (m_st == 3) begin
            il = (v != 0 && s == 3) ? 1 : 0;
            m_st = 0;
        end else if (v != 0) begin
            case (m_st)
                0: if (s == 3) il = 1;
                   else begin m_exp = nx(s); m_good = 0; m_st = 1; end
                1: if (s == 3) begin il = 1; m_st = 0; end
                   else if (s == m_exp) begin
                       m_good++; m_exp = nx(s);
                       if (m_good == LOCK_N) begin m_st = 2; m_bad = 0; end
                   end else begin m_good = 0; m_exp = nx(s); end
                default: begin
                    if (s == 3) il = 1;
                    if (s == m_exp) m_bad = 0;
                    else begin
                        ep = 1; m_bad++;
                        if (m_bad == LOSS_N) begin ls = 1; m_st = 3; end
                    end
                    m_exp = nx(m_exp);
                end
            endcase
        end
        if (c != 0) begin m_errc = 0; m_errs = 0; end
        else if (ep != 0) begin
            if (m_errc < 255) m_errc++;
            if (m_errs < 3) m_errs++;
        end
        e.lk = (m_st == 2) ? 1 : 0; e.ex = m_exp; e.ep = ep; e.il = il;
        e.ls = ls; e.ec = m_errc; e.es = m_errs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked",    int'(locked_a),    e.lk);
        chk("expected",  int'(expected_a),  e.ex);
        chk("err_pulse", int'(err_pulse_a), e.ep);
        chk("illegal",   int'(illegal_a),   e.il);
        chk("lost",      int'(lost_a),      e.ls);
        chk("err_count", int'(err_count_a), e.ec);
        chk("err_sat",   int'(err_count_b), e.es);
        chk("locked_s",  int'(locked_b),    e.lk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_locked"},   int'(locked_a),    0);
        chk({tag, "_expected"}, int'(expected_a),  0);
        chk({tag, "_errp"},     int'(err_pulse_a), 0);
        chk({tag, "_illegal"},  int'(illegal_a),   0);
        chk({tag, "_lost"},     int'(lost_a),      0);
        chk({tag, "_errc"},     int'(err_count_a), 0);
        chk({tag, "_errs"},     int'(err_count_b), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire lock on the 4th symbol
        step(1, 0, 0); step(1, 1, 0); step(1, 2, 0); step(1, 0, 0);
        chk("lock_after_4", int'(locked_a), 1);

        // One bad symbol, then the flywheel prediction matches
        step(1, 2, 0); step(1, 2, 0);
        step(0, 3, 0); step(0, 1, 0);

        // Two illegal symbols drop lock, then LOST -> HUNT
        step(1, 3, 0); step(1, 3, 0); step(0, 0, 0); step(1, 3, 0);

        // Relock, clear, then alternate mismatch / match five times
        step(1, 1, 0); step(1, 2, 0); step(1, 0, 0); step(1, 1, 0);
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, nx(m_exp), 0);
            step(1, m_exp, 0);
        end
        chk("sat_locked", int'(locked_b), 1);

        // Clear coincident with a mismatch
        step(1, nx(m_exp), 1);
        step(1, m_exp, 0);

        // Gaps with a pending error, then asynchronous reset mid-lock
        step(1, nx(m_exp), 0);
        step(0, m_exp, 0);
        step(0, 3, 0);
        #2;
        in_valid = 1'b1;
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("held");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, mostly on-sequence symbols
        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step((r != 0) ? 1 : 0,
                 (r < 7) ? m_exp : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
